// File: rtl/player_motion.sv
// Player physics stage: per frame_tick, handshakes one scan with the collision stage
// and then applies horizontal motion, gravity, landing, jumping and screen clamping.
module player_motion #(
    parameter int WIDTH    = 10,
    parameter int HEIGHT   = 20,
    parameter int H_SPEED  = 2,
    parameter int JUMP_V   = 10,
    parameter int MAX_FALL = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_jump,
    input  logic        col_up,
    input  logic        col_down,
    input  logic        col_left,
    input  logic        col_right,
    input  logic        col_done,
    input  logic [43:0] col_object,
    output logic        col_start,
    output logic        col_redo,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        grounded,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned PW = 12;
    localparam int unsigned VW = 6;

    localparam logic signed [PW-1:0] ONE   = PW'(1);
    localparam logic signed [PW-1:0] ZERO  = PW'(0);
    localparam logic signed [PW-1:0] X_MAX = PW'(639 - WIDTH);
    localparam logic signed [PW-1:0] Y_MAX = PW'(479 - HEIGHT);
    localparam logic signed [PW-1:0] W_S   = PW'(WIDTH);
    localparam logic signed [PW-1:0] H_S   = PW'(HEIGHT);
    localparam logic signed [PW-1:0] SPD   = PW'(H_SPEED);

    localparam logic signed [VW-1:0] VY_JUMP = VW'(-JUMP_V);
    localparam logic signed [VW-1:0] VY_MAX  = VW'(MAX_FALL);
    localparam logic signed [VW-1:0] VY_ONE  = VW'(1);
    localparam logic [XW-1:0]        X_RST   = XW'(100);
    localparam logic [YW-1:0]        Y_RST   = YW'(100);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_UPDATE,
        S_RELEASE
    } state_t;

    state_t state, state_n;
    logic key_l, key_r, key_j;
    logic signed [VW-1:0] vy;

    logic signed [PW-1:0] x_s, y_s, vy_s, left_s, top_s, right_s, bottom_s;
    logic signed [PW-1:0] x_c, y_c;
    logic signed [VW-1:0] vy_c, land_vy;
    logic                 g_c, go_r, go_l;

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (frame_tick) state_n = S_START;
            S_START:   state_n = S_WAIT;
            S_WAIT:    if (col_done) state_n = S_UPDATE;
            S_UPDATE:  state_n = S_RELEASE;
            S_RELEASE: state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    assign x_s      = $signed(PW'(x));
    assign y_s      = $signed(PW'(y));
    assign vy_s     = PW'(vy);
    assign left_s   = $signed(PW'(col_object[43:33]));
    assign top_s    = $signed(PW'(col_object[32:22]));
    assign right_s  = $signed(PW'(col_object[21:11]));
    assign bottom_s = $signed(PW'(col_object[10:0]));
    assign go_r     = key_r & ~key_l;
    assign go_l     = key_l & ~key_r;
    assign land_vy  = key_j ? VY_JUMP : '0;

    // Horizontal move with wall snap, then screen clamp
    always_comb begin
        x_c = x_s;
        if (go_r && col_right)     x_c = left_s - W_S - ONE;
        else if (go_l && col_left) x_c = right_s + ONE;
        else if (go_r)             x_c = x_s + SPD;
        else if (go_l)             x_c = x_s - SPD;
        if (x_c < ZERO)            x_c = ZERO;
        else if (x_c > X_MAX)      x_c = X_MAX;
    end

    // Vertical: ceiling bump, landing/jump, or gravity; the screen bottom acts as a floor
    always_comb begin
        y_c  = y_s + vy_s;
        vy_c = (vy >= VY_MAX) ? VY_MAX : vy + VY_ONE;
        g_c  = 1'b0;
        if (col_up && vy[VW-1]) begin
            y_c  = bottom_s + ONE;
            vy_c = '0;
        end else if (col_down && !vy[VW-1]) begin
            y_c  = top_s - H_S - ONE;
            vy_c = land_vy;
            g_c  = 1'b1;
        end
        if (y_c > Y_MAX) begin
            y_c  = Y_MAX;
            vy_c = land_vy;
            g_c  = 1'b1;
        end else if (y_c < ZERO) begin
            y_c  = ZERO;
            vy_c = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            x         <= X_RST;
            y         <= Y_RST;
            vy        <= '0;
            grounded  <= 1'b0;
            col_start <= 1'b0;
            col_redo  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            key_l     <= 1'b0;
            key_r     <= 1'b0;
            key_j     <= 1'b0;
        end else begin
            state     <= state_n;
            col_start <= (state_n == S_START);
            col_redo  <= (state_n == S_RELEASE);
            busy      <= (state_n != S_IDLE);
            overrun   <= frame_tick && (state != S_IDLE);
            if (state == S_IDLE && frame_tick) begin
                key_l <= key_left;
                key_r <= key_right;
                key_j <= key_jump;
            end
            if (state == S_UPDATE) begin
                x        <= XW'(x_c);
                y        <= YW'(y_c);
                vy       <= vy_c;
                grounded <= g_c;
            end
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: directed frames push expected position into a scoreboard,
// a monitor compares whenever col_redo shows the freshly updated position.
module tb_player_motion;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick, key_left, key_right, key_jump;
    logic        col_up, col_down, col_left, col_right, col_done;
    logic [43:0] col_object;
    logic        col_start, col_redo, grounded, busy, overrun;
    logic [9:0]  x;
    logic [8:0]  y;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       g;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   frame_no = 0;

    player_motion dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
        .col_up(col_up), .col_down(col_down), .col_left(col_left), .col_right(col_right),
        .col_done(col_done), .col_object(col_object),
        .col_start(col_start), .col_redo(col_redo), .x(x), .y(y),
        .grounded(grounded), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (frame %0d): got %0d, expected %0d", name, frame_no, act, exp);
        end
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (col_redo) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected (frame %0d): col_redo with empty scoreboard", frame_no);
                end else begin
                    e = sb.pop_front();
                    chk("x", int'(x), int'(e.x));
                    chk("y", int'(y), int'(e.y));
                    chk("grounded", int'(grounded), int'(e.g));
                end
            end
        end
    end

    // k = {left,right,jump}, c = {up,down,left,right}
    task automatic run_frame(input logic [2:0] k, input logic [3:0] c,
                             input int lx, input int ty, input int rx, input int by,
                             input int ex, input int ey, input int eg,
                             input int dly, input bit ov_wait, input bit ov_rel);
        int   n;
        exp_t e;
        frame_no++;
        e.x = 10'(ex);
        e.y = 9'(ey);
        e.g = 1'(eg);
        sb.push_back(e);
        {key_left, key_right, key_jump} = k;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        {key_left, key_right, key_jump} = ~k;
        chk("col_start_hi", int'(col_start), 1);
        chk("busy_hi", int'(busy), 1);
        @(negedge clk);
        chk("col_start_lo", int'(col_start), 0);
        if (ov_wait) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            chk("overrun_wait", int'(overrun), 1);
            @(negedge clk);
            chk("overrun_clear", int'(overrun), 0);
        end
        for (int i = 0; i < dly; i++) @(negedge clk);
        {col_up, col_down, col_left, col_right} = c;
        col_object = {11'(lx), 11'(ty), 11'(rx), 11'(by)};
        col_done   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!col_redo && n < 8);
        chk("redo_latency", n, 2);
        if (ov_rel) frame_tick = 1'b1;
        col_done = 1'b0;
        {col_up, col_down, col_left, col_right} = 4'b0000;
        col_object = '0;
        @(negedge clk);
        frame_tick = 1'b0;
        {key_left, key_right, key_jump} = 3'b000;
        chk("redo_lo", int'(col_redo), 0);
        chk("busy_lo", int'(busy), 0);
        if (ov_rel) begin
            chk("overrun_release", int'(overrun), 1);
            @(negedge clk);
            chk("release_not_queued", int'(busy), 0);
        end
    endtask

    initial begin
        int redo_seen;
        reset = 1'b1;
        {frame_tick, key_left, key_right, key_jump} = 4'b0000;
        {col_up, col_down, col_left, col_right, col_done} = 5'b00000;
        col_object = '0;
        repeat (2) @(negedge clk);
        chk("rst_x", int'(x), 100);
        chk("rst_y", int'(y), 100);
        chk("rst_grounded", int'(grounded), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_col_start", int'(col_start), 0);
        chk("rst_col_redo", int'(col_redo), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        @(negedge clk);

        // free fall
        run_frame(3'b000, 4'b0000,   0,   0,  0,   0, 100, 100, 0, 7, 0, 0);
        run_frame(3'b000, 4'b0000,   0,   0,  0,   0, 100, 101, 0, 3, 1, 0);
        run_frame(3'b000, 4'b0000,   0,   0,  0,   0, 100, 103, 0, 1, 0, 1);
        run_frame(3'b000, 4'b0000,   0,   0,  0,   0, 100, 106, 0, 0, 0, 0);
        // landing, jump, rise
        run_frame(3'b000, 4'b0100,   0, 200,  0,   0, 100, 179, 1, 2, 0, 0);
        run_frame(3'b001, 4'b0100,   0, 200,  0,   0, 100, 179, 1, 0, 0, 0);
        run_frame(3'b000, 4'b0000,   0,   0,  0,   0, 100, 169, 0, 0, 0, 0);
        // walls and horizontal moves
        run_frame(3'b010, 4'b0001, 115,   0,  0,   0, 104, 160, 0, 0, 0, 0);
        run_frame(3'b110, 4'b0000,   0,   0,  0,   0, 104, 152, 0, 0, 0, 0);
        run_frame(3'b100, 4'b0000,   0,   0,  0,   0, 102, 145, 0, 0, 0, 0);
        run_frame(3'b000, 4'b1000,   0,   0,  0, 130, 102, 131, 0, 0, 0, 0);
        run_frame(3'b100, 4'b0010,   0,   0, 50,   0,  51, 131, 0, 0, 0, 0);
        run_frame(3'b010, 4'b0001, 639,   0,  0,   0, 628, 132, 0, 0, 0, 0);
        run_frame(3'b010, 4'b0000,   0,   0,  0,   0, 629, 134, 0, 0, 0, 0);
        // screen floor
        run_frame(3'b000, 4'b0100,   0, 479,  0,   0, 629, 458, 1, 0, 0, 0);
        run_frame(3'b000, 4'b0000,   0,   0,  0,   0, 629, 458, 0, 0, 0, 0);
        run_frame(3'b000, 4'b0000,   0,   0,  0,   0, 629, 459, 0, 0, 0, 0);
        run_frame(3'b000, 4'b0000,   0,   0,  0,   0, 629, 459, 1, 0, 0, 0);
        run_frame(3'b001, 4'b0000,   0,   0,  0,   0, 629, 459, 0, 0, 0, 0);
        run_frame(3'b001, 4'b0000,   0,   0,  0,   0, 629, 459, 1, 0, 0, 0);
        run_frame(3'b000, 4'b0000,   0,   0,  0,   0, 629, 449, 0, 0, 0, 0);
        // left screen edge
        run_frame(3'b010, 4'b0001,   5,   0,  0,   0,   0, 440, 0, 0, 0, 0);
        run_frame(3'b100, 4'b0000,   0,   0,  0,   0,   0, 432, 0, 0, 0, 0);

        // reset while waiting on the collision stage
        frame_no++;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midwait_busy", int'(busy), 0);
        chk("midwait_x", int'(x), 100);
        chk("midwait_y", int'(y), 100);
        chk("midwait_grounded", int'(grounded), 0);
        @(negedge clk);
        reset = 1'b0;
        redo_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (col_redo || busy) redo_seen++;
        end
        chk("midwait_quiet", redo_seen, 0);

        // vy cleared by reset: first update leaves y in place
        run_frame(3'b000, 4'b0000,   0,   0,  0,   0, 100, 100, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_motion.md
PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 SHALL have parameter WIDTH, default 10, player sprite width in pixels (matches collision stage).
REQ-002 SHALL have parameter HEIGHT, default 20, player sprite height in pixels (matches collision stage).
REQ-003 SHALL have parameter H_SPEED, default 2, horizontal pixels moved per frame.
REQ-004 SHALL have parameter JUMP_V, default 10, upward launch speed in pixels per frame.
REQ-005 SHALL have parameter MAX_FALL, default 8, terminal downward speed in pixels per frame.
REQ-006 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port frame_tick  input  1  one-cycle pulse requesting one physics update.
REQ-009 SHALL have port key_left  input  1  move-left request, sampled on accepted frame_tick.
REQ-010 SHALL have port key_right  input  1  move-right request, sampled on accepted frame_tick.
REQ-011 SHALL have port key_jump  input  1  jump request, sampled on accepted frame_tick.
REQ-012 SHALL have ports col_up, col_down, col_left, col_right  input  1 each  collision-stage contact flags.
REQ-013 SHALL have port col_done  input  1  collision stage scan complete, held until col_redo.
REQ-014 SHALL have port col_object  input  44  contact edges {left_x[43:33], top_y[32:22], right_x[21:11], bottom_y[10:0]}.
REQ-015 SHALL have port col_start  output  1  one-cycle scan request to collision stage.
REQ-016 SHALL have port col_redo  output  1  one-cycle release/re-arm of collision stage.
REQ-017 SHALL have port x  output  10  player left edge, fed to collision stage.
REQ-018 SHALL have port y  output  9  player top edge, fed to collision stage.
REQ-019 SHALL have ports grounded, busy, overrun  output  1 each  standing on surface / FSM not IDLE / one-cycle pulse on dropped frame_tick.

Function
REQ-020 SHALL implement FSM IDLE->START->WAIT->UPDATE->RELEASE->IDLE; frame_tick in IDLE moves to START and latches key_*; START lasts one cycle with col_start=1; WAIT holds until col_done=1; UPDATE lasts one cycle; RELEASE lasts one cycle with col_redo=1.
REQ-021 SHALL hold x and y constant in all states except the UPDATE edge; new x, y, vy, grounded visible the cycle after UPDATE.
REQ-022 SHALL keep internal signed vy (6 bits min); all position arithmetic in 12-bit signed, clamped before truncation to 10/9 bits.
REQ-023 Horizontal: dir=+1 if only right latched, -1 if only left, 0 if both or neither.
REQ-024 If dir=+1 and col_right: x_n=left_x-WIDTH-1; if dir=-1 and col_left: x_n=right_x+1; else x_n=x+dir*H_SPEED.
REQ-025 x_n SHALL clamp to 0..(639-WIDTH).
REQ-026 Vertical, priority order: col_up and vy<0 -> y_n=bottom_y+1, vy=0, grounded=0; else col_down and vy>=0 -> y_n=top_y-HEIGHT-1, grounded=1, vy=-JUMP_V if jump latched else 0; else y_n=y+vy, vy=min(vy+1, MAX_FALL), grounded=0.
REQ-027 y_n>(479-HEIGHT) SHALL clamp to 479-HEIGHT with floor-landing rule of REQ-026 (grounded=1, vy 0 or -JUMP_V); y_n<0 SHALL clamp to 0 with vy=0.
REQ-028 frame_tick in any non-IDLE state SHALL be dropped and pulse overrun for one cycle; the in-flight update completes unaffected.
REQ-029 frame_tick arriving in the RELEASE cycle SHALL be dropped (overrun pulse), not queued.
REQ-030 busy SHALL equal (state != IDLE).

Reset
REQ-031 reset SHALL immediately force IDLE, x=100, y=100, vy=0, grounded=0, col_start=0, col_redo=0, overrun=0, latched keys=0.
REQ-032 reset asserted mid-WAIT SHALL abandon the scan without issuing col_redo; the collision stage is re-armed by its own reset.

Verification
REQ-033 Free fall: reset, no contacts, 3 ticks -> y=100,100,101,103 after ticks 0..3 (vy 1,2,3).
REQ-034 Landing: y=100, vy=4, col_down=1, top_y=200 -> y=179, vy=0, grounded=1.
REQ-035 Jump: grounded, key_jump, col_down=1, top_y=200 -> vy=-10; next tick without contact -> y decreases by 10.
REQ-036 Wall: x=100, key_right, col_right=1, left_x=115 -> x=104; key_left+key_right, no contact -> x unchanged.
REQ-037 Handshake: tick -> col_start high exactly 1 cycle; col_done after 7 cycles -> col_redo 2 cycles later; tick during WAIT -> overrun pulse, single update.
REQ-038 Bounds: x=628, key_right -> x=629; y=458, vy=8 -> y=459, grounded=1.
